// File: rtl/tennis_score_display_ctrl.sv
// Score formatter feeding the seven-segment scan driver: latches tennis or
// squash scores on a strobe, formats them into digit enables and segment
// words, and runs blink animations after a point or a game.
module tennis_score_display_ctrl #(
  parameter int N_DIGITS     = 8,
  parameter int PTS_W        = 4,
  parameter int GAME_W       = 4,
  parameter int BLINK_DIV    = 25_000_000,
  parameter int FLASH_BLINKS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  upd,
  input  logic [PTS_W-1:0]      p0_pts,
  input  logic [PTS_W-1:0]      p1_pts,
  input  logic [GAME_W-1:0]     p0_games,
  input  logic [GAME_W-1:0]     p1_games,
  output logic [N_DIGITS-1:0]   an_en,
  output logic [7*N_DIGITS-1:0] seg_data,
  output logic                  busy,
  output logic                  game_pt
);

  localparam int TIMER_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int HP_W    = (2 * FLASH_BLINKS > 1) ? $clog2(2 * FLASH_BLINKS) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BLINK_DIV - 1);
  localparam logic [HP_W-1:0]    HP_LAST    = HP_W'(2 * FLASH_BLINKS - 1);

  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_P     = 7'b1110011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;

  typedef enum logic [1:0] {SHOW, FLASH, WIN} state_t;

  state_t              state;
  logic [TIMER_W-1:0]  timer;
  logic [HP_W-1:0]     half_cnt;
  logic                scorer;
  logic                mode_q;
  logic [PTS_W-1:0]    p0_pts_q, p1_pts_q;
  logic [GAME_W-1:0]   p0_games_q, p1_games_q;

  logic [7:0][6:0]     dig;
  logic [7:0]          en8;
  logic [7:0]          blank_mask;
  logic                gp_next;

  logic                games_chg, p0_inc, p1_inc;
  logic [2:0]          a, b;
  logic                deuce, adv0, adv1, gp0, gp1;

  function automatic logic [6:0] dec_code(input logic [3:0] v);
    case (v)
      4'd0:    dec_code = 7'b0111111;
      4'd1:    dec_code = 7'b0000110;
      4'd2:    dec_code = 7'b1011011;
      4'd3:    dec_code = 7'b1001111;
      4'd4:    dec_code = 7'b1100110;
      4'd5:    dec_code = 7'b1101101;
      4'd6:    dec_code = 7'b1111101;
      4'd7:    dec_code = 7'b0000111;
      4'd8:    dec_code = 7'b1111111;
      4'd9:    dec_code = 7'b1101111;
      default: dec_code = SEG_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] games_digit(input logic [GAME_W-1:0] g);
    games_digit = (32'(g) > 32'd9) ? 4'd9 : 4'(g);
  endfunction

  function automatic logic [3:0] tens_of(input logic [PTS_W-1:0] v);
    int unsigned x;
    x = 32'(v);
    if (x > 99) x = 99;
    tens_of = 4'(x / 10);
  endfunction

  function automatic logic [3:0] ones_of(input logic [PTS_W-1:0] v);
    int unsigned x;
    x = 32'(v);
    if (x > 99) x = 99;
    ones_of = 4'(x % 10);
  endfunction

  assign games_chg = (p0_games != p0_games_q) || (p1_games != p1_games_q);
  assign p0_inc    = p0_pts > p0_pts_q;
  assign p1_inc    = p1_pts > p1_pts_q;

  // Score latches, animation state, blink timer and half-period counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SHOW;
      timer      <= '0;
      half_cnt   <= '0;
      scorer     <= 1'b0;
      busy       <= 1'b0;
      mode_q     <= 1'b0;
      p0_pts_q   <= '0;
      p1_pts_q   <= '0;
      p0_games_q <= '0;
      p1_games_q <= '0;
    end else if (upd) begin
      mode_q     <= mode;
      p0_pts_q   <= p0_pts;
      p1_pts_q   <= p1_pts;
      p0_games_q <= p0_games;
      p1_games_q <= p1_games;
      timer      <= '0;
      half_cnt   <= '0;
      if (mode != mode_q) begin
        state <= SHOW;
        busy  <= 1'b0;
      end else if (games_chg) begin
        state <= WIN;
        busy  <= 1'b1;
      end else if (p0_inc || p1_inc) begin
        state  <= FLASH;
        busy   <= 1'b1;
        scorer <= !p0_inc;
      end
    end else if (state != SHOW) begin
      if (timer == TIMER_LAST) begin
        timer <= '0;
        if (half_cnt == HP_LAST) begin
          half_cnt <= '0;
          state    <= SHOW;
          busy     <= 1'b0;
        end else begin
          half_cnt <= half_cnt + HP_W'(1);
        end
      end else begin
        timer <= timer + TIMER_W'(1);
      end
    end
  end

  // Format the latched scores into eight digit codes, enables and blink mask.
  always_comb begin
    dig        = '0;
    en8        = '0;
    gp_next    = 1'b0;
    blank_mask = '0;
    a          = (32'(p0_pts_q) > 32'd4) ? 3'd4 : 3'(p0_pts_q);
    b          = (32'(p1_pts_q) > 32'd4) ? 3'd4 : 3'(p1_pts_q);
    deuce      = (a >= 3'd3) && (a == b);
    adv0       = (a == 3'd4) && (b == 3'd3);
    adv1       = (a == 3'd3) && (b == 3'd4);
    gp0        = adv0 || ((a == 3'd3) && (b < 3'd3));
    gp1        = adv1 || ((b == 3'd3) && (a < 3'd3));
    if (!mode_q) begin
      dig[7] = dec_code(games_digit(p0_games_q));
      dig[0] = dec_code(games_digit(p1_games_q));
      dig[5] = adv0 ? SEG_A : (deuce ? dec_code(4'd3) : dec_code({1'b0, a}));
      dig[2] = adv1 ? SEG_A : (deuce ? dec_code(4'd3) : dec_code({1'b0, b}));
      en8    = 8'b10100101;
      if (deuce) begin
        dig[4] = SEG_D;
        dig[3] = SEG_E;
        en8    = 8'b10111101;
      end else if (gp0 || gp1) begin
        dig[4]  = SEG_P;
        dig[3]  = gp0 ? dec_code(4'd1) : dec_code(4'd2);
        en8     = 8'b10111101;
        gp_next = 1'b1;
      end
    end else begin
      if (tens_of(p0_pts_q) != 4'd0) begin
        dig[7] = dec_code(tens_of(p0_pts_q));
        en8[7] = 1'b1;
      end
      dig[6] = dec_code(ones_of(p0_pts_q));
      en8[6] = 1'b1;
      if (tens_of(p1_pts_q) != 4'd0) begin
        dig[1] = dec_code(tens_of(p1_pts_q));
        en8[1] = 1'b1;
      end
      dig[0] = dec_code(ones_of(p1_pts_q));
      en8[0] = 1'b1;
    end
    if (state != SHOW && !half_cnt[0]) begin
      if (state == WIN)
        blank_mask = 8'hFF;
      else if (!scorer)
        blank_mask = mode_q ? 8'b11000000 : 8'b00100000;
      else
        blank_mask = mode_q ? 8'b00000011 : 8'b00000100;
    end
  end

  // Register the display outputs; animations only gate the enables.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_en    <= '0;
      seg_data <= '0;
      game_pt  <= 1'b0;
    end else begin
      an_en    <= N_DIGITS'(en8 & ~blank_mask);
      seg_data <= (7 * N_DIGITS)'(dig);
      game_pt  <= gp_next;
    end
  end

endmodule
